lfsr_word_capture: RTL

Serial-to-parallel capture stage fed by the serial output `q` of the LFSR chain. It samples one bit per rising clock edge while enabled, and packs bits first-bit-to-MSB into `WIDTH`-bit words. Completed words are presented through a 2-entry buffered valid/ready port. It also reports stuck-line runs and buffer overflow, so a bench or host can consume the stream without a hand-written capture loop.

---
 rtl/lfsr_cap_pkg.sv | 21 ++
 rtl/lfsr_word_fifo.sv | 76 +++++++
 rtl/lfsr_word_capture.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lfsr_cap_pkg.sv
// Shared types and default constants for the LFSR serial word capture stage.
package lfsr_cap_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } cap_state_e;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 2;
    localparam int DEF_STUCK_LEN = 64;
    localparam int DEF_CNT_W     = 16;

    // Bit index counts 0..WIDTH-1, so $clog2(WIDTH) bits are enough.
    localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/lfsr_word_fifo.sv
// Small register FIFO, head always in entry 0. Accepts a push while full
// when a pop happens on the same edge. When drained, the head entry keeps
// its last word so rdata holds steady.
module lfsr_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_req,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] ent_q [DEPTH];
    logic [WIDTH-1:0] ent_d [DEPTH];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    cnt_after;
    logic             pop;
    logic             push_ok;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign rdata = ent_q[0];

    // Next-state: shift entries toward the head on pop, write the tail on push.
    always_comb begin
        ent_d     = ent_q;
        cnt_d     = cnt_q;
        pop       = pop_req && valid;
        push_ok   = push && (!full || pop);
        cnt_after = pop ? (cnt_q - CW'(1)) : cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if ((i + 1) < int'(cnt_q)) begin
                        ent_d[i] = ent_q[i + 1];
                    end
                end
            end
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(cnt_after)) begin
                        ent_d[i] = wdata;
                    end
                end
            end
            cnt_d = cnt_after + CW'(push_ok);
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: rtl/lfsr_word_capture.sv
// Serial-to-parallel capture of the LFSR chain output: packs bits MSB-first
// into words, buffers them, and reports drops and stuck-line runs.
module lfsr_word_capture
    import lfsr_cap_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int STUCK_LEN = DEF_STUCK_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow,
    output logic             stuck
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam int RUN_W = $clog2(STUCK_LEN + 1);

    cap_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic             word_done;
    logic             fifo_full;
    logic             pop;
    logic             drop;

    assign pop  = out_valid && out_ready;
    assign drop = word_done && fifo_full && !pop;

    // Shifter and IDLE/FILL sequencing; idx counts bits already in the word.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            shift_d = '0;
        end else if (en) begin
            shift_d = {shift_q[WIDTH-2:0], d};
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    idx_d   = IDX_W'(1);
                end
                default: begin
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        word_done = 1'b1;
                        state_d   = ST_IDLE;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    // Word/drop counters, sticky overflow and the run-length detector.
    always_comb begin
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        run_d      = run_q;
        last_d     = last_q;
        if (clear) begin
            word_cnt_d = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
            run_d      = '0;
            last_d     = 1'b0;
        end else begin
            if (word_done && !drop) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {CNT_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
            if (en) begin
                last_d = d;
                if (d != last_q) begin
                    run_d = RUN_W'(1);
                end else if (run_q != RUN_W'(STUCK_LEN)) begin
                    run_d = run_q + RUN_W'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            run_q      <= '0;
            last_q     <= 1'b0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            run_q      <= run_d;
            last_q     <= last_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;
    assign stuck    = (run_q == RUN_W'(STUCK_LEN));

    lfsr_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (clear),
        .push    (word_done),
        .wdata   (shift_d),
        .pop_req (out_ready),
        .rdata   (out_data),
        .valid   (out_valid),
        .full    (fifo_full)
    );

endmodule
